// File: rtl/pifo_task_issuer.sv
// Host-side task issuer for one PIFO lane: issues push/pop tasks under backpressure and pop credits,
// collects level-0 pop results in a FWFT response FIFO and checks them in order against issued pops.
module pifo_task_issuer #(
   parameter int unsigned PTW       = 16,
   parameter int unsigned MTW       = 0,
   parameter int unsigned TREE_NUM  = 4,
   parameter int unsigned RSP_DEPTH = 8,
   parameter int unsigned TIMEOUT   = 255,
   localparam int unsigned DW       = PTW + MTW,
   localparam int unsigned TIDW     = $clog2(TREE_NUM),
   localparam int unsigned CNTW     = $clog2(TIMEOUT + 1),
   localparam int unsigned AW       = $clog2(RSP_DEPTH),
   localparam int unsigned OCW      = AW + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   input  logic            i_req_is_push,
   input  logic [TIDW-1:0] i_req_tree_id,
   input  logic [DW-1:0]   i_req_data,
   output logic            o_req_ready,
   output logic            o_push,
   output logic            o_pop,
   output logic [TIDW-1:0] o_tree_id,
   output logic [DW-1:0]   o_push_data,
   input  logic            i_task_fifo_full,
   input  logic            i_pop_valid,
   input  logic [TIDW-1:0] i_pop_tree_id,
   input  logic [DW-1:0]   i_pop_data,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [TIDW-1:0] o_rsp_tree_id,
   output logic [DW-1:0]   o_rsp_data,
   output logic            o_rsp_empty,
   output logic            o_err_order,
   output logic            o_err_timeout,
   output logic [OCW-1:0]  o_outstanding
);

   localparam logic [OCW-1:0]  DEPTH_C   = OCW'(RSP_DEPTH);
   localparam logic [OCW:0]    CREDIT_C  = (OCW + 1)'(RSP_DEPTH);
   localparam logic [CNTW-1:0] TO_C      = CNTW'(TIMEOUT);
   localparam logic [CNTW-1:0] TO_M1_C   = CNTW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP
   } state_t;

   state_t state_q, state_d;

   logic            accept;
   logic            credit_ok;
   logic [OCW:0]    credit_sum;
   logic            tag_wr, tag_rd;
   logic [TIDW-1:0] tag_mem [RSP_DEPTH];
   logic [AW-1:0]   tag_wp, tag_rp;
   logic [TIDW-1:0] tag_head;

   logic [TIDW+DW-1:0] rsp_mem [RSP_DEPTH];
   logic [AW-1:0]      rsp_wp, rsp_rp;
   logic [OCW-1:0]     rsp_cnt;
   logic               rsp_wr, rsp_rd;
   logic [TIDW+DW-1:0] rsp_head;

   logic [CNTW-1:0] age_q;

   // Credits count both in-flight pops and results parked in the response FIFO
   assign credit_sum = {1'b0, o_outstanding} + {1'b0, rsp_cnt};
   assign credit_ok  = credit_sum < CREDIT_C;

   always_comb begin
      o_req_ready = !i_rst && !i_task_fifo_full && (state_q != S_ISSUE)
                    && (i_req_is_push || credit_ok);
      accept      = i_req_valid && o_req_ready;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_ISSUE;
         S_ISSUE: state_d = S_GAP;
         S_GAP:   state_d = accept ? S_ISSUE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         o_push      <= 1'b0;
         o_pop       <= 1'b0;
         o_tree_id   <= '0;
         o_push_data <= '0;
      end else begin
         state_q <= state_d;
         o_push  <= accept && i_req_is_push;
         o_pop   <= accept && !i_req_is_push;
         if (accept) begin
            o_tree_id   <= i_req_tree_id;
            o_push_data <= i_req_is_push ? i_req_data : '0;
         end
      end
   end

   // Tag FIFO occupancy is o_outstanding itself; only pointers are kept
   assign tag_wr   = accept && !i_req_is_push;
   assign tag_rd   = i_pop_valid && (o_outstanding != '0);
   assign tag_head = tag_mem[tag_rp];

   always_ff @(posedge i_clk) begin
      if (tag_wr) tag_mem[tag_wp] <= i_req_tree_id;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_wp        <= '0;
         tag_rp        <= '0;
         o_outstanding <= '0;
         o_err_order   <= 1'b0;
      end else begin
         if (tag_wr) tag_wp <= tag_wp + 1'b1;
         if (tag_rd) tag_rp <= tag_rp + 1'b1;
         unique case ({tag_wr, tag_rd})
            2'b10:   o_outstanding <= o_outstanding + 1'b1;
            2'b01:   o_outstanding <= o_outstanding - 1'b1;
            default: o_outstanding <= o_outstanding;
         endcase
         if (i_pop_valid && ((o_outstanding == '0) || (i_pop_tree_id != tag_head)))
            o_err_order <= 1'b1;
      end
   end

   assign rsp_rd   = o_rsp_valid && i_rsp_ready;
   assign rsp_wr   = i_pop_valid && (rsp_cnt != DEPTH_C);
   assign rsp_head = rsp_mem[rsp_rp];

   always_ff @(posedge i_clk) begin
      if (rsp_wr) rsp_mem[rsp_wp] <= {i_pop_tree_id, i_pop_data};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rsp_wp  <= '0;
         rsp_rp  <= '0;
         rsp_cnt <= '0;
      end else begin
         if (rsp_wr) rsp_wp <= rsp_wp + 1'b1;
         if (rsp_rd) rsp_rp <= rsp_rp + 1'b1;
         unique case ({rsp_wr, rsp_rd})
            2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
            2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
            default: rsp_cnt <= rsp_cnt;
         endcase
      end
   end

   // Head is gated so stale storage never shows on the outputs while empty
   always_comb begin
      o_rsp_valid   = rsp_cnt != '0;
      o_rsp_tree_id = o_rsp_valid ? rsp_head[DW +: TIDW] : '0;
      o_rsp_data    = o_rsp_valid ? rsp_head[DW-1:0] : '0;
      o_rsp_empty   = o_rsp_valid && (&o_rsp_data);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         age_q         <= '0;
         o_err_timeout <= 1'b0;
      end else if (i_pop_valid || (o_outstanding == '0)) begin
         age_q <= '0;
      end else if (age_q != TO_C) begin
         age_q <= age_q + 1'b1;
         if (age_q == TO_M1_C) o_err_timeout <= 1'b1;
      end
   end

endmodule
